// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Requester side of the ALU interface in the multi-cycle datapath.  A request
// carries an RV32 instruction word plus rs1/rs2/immediate values.  The block
// decodes opcode/funct3/funct7 into the 4-bit ALUCtl code and registers the
// operands and control into the combinational ALU.  It holds them for
// EXEC_CYCLES cycles, then samples ALUOut/zero.  It returns the result, the
// branch decision and an illegal-encoding flag on a valid/ready response
// channel.
//
// Parameters
//   XLEN         datapath width (operands, ALU result, response result)
//   EXEC_CYCLES  cycles the ALU inputs are held before sampling (1..15)
//
// Optional feature (compile-time macro ALU_TZCNT_EN)
//   Defined     : custom-0 opcode 0001011 with funct3 001 issues TZCNT
//                 (ALUCtl 1111) with A=rs1, B=0.
//   Not defined : that encoding is reported as illegal and 1111 never
//                 appears on o_alu_ctl.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_flush        synchronous abort of any in-flight operation
//   i_req_valid    request present
//   o_req_ready    request accepted when valid & ready
//   i_req_instr    32-bit instruction word
//   i_req_rs1      rs1 value
//   i_req_rs2      rs2 value
//   i_req_imm      sign-extended immediate
//   o_alu_a        registered ALU operand A
//   o_alu_b        registered ALU operand B
//   o_alu_ctl      registered ALUCtl code
//   i_alu_out      ALU result
//   i_alu_zero     ALU zero flag
//   o_rsp_valid    response present
//   i_rsp_ready    response consumed when valid & ready
//   o_rsp_result   sampled ALU result (0 for an illegal encoding)
//   o_rsp_taken    branch taken (0 for non-branches)
//   o_rsp_illegal  unsupported encoding
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int XLEN        = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [31:0]     i_req_instr,
  input  logic [XLEN-1:0] i_req_rs1,
  input  logic [XLEN-1:0] i_req_rs2,
  input  logic [XLEN-1:0] i_req_imm,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctl,
  input  logic [XLEN-1:0] i_alu_out,
  input  logic            i_alu_zero,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_result,
  output logic            o_rsp_taken,
  output logic            o_rsp_illegal
);

  // ALUCtl encodings understood by the ALU
  localparam logic [3:0] CTL_ADD   = 4'b0000;
  localparam logic [3:0] CTL_SUB   = 4'b0001;
  localparam logic [3:0] CTL_SLT   = 4'b0010;
  localparam logic [3:0] CTL_OR    = 4'b0011;
  localparam logic [3:0] CTL_AND   = 4'b0100;
`ifdef ALU_TZCNT_EN
  localparam logic [3:0] CTL_TZCNT = 4'b1111;
`endif

  // Opcodes handled by this block
  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
`ifdef ALU_TZCNT_EN
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
`endif

  // Counter value on the last hold cycle; EXEC_CYCLES is limited to 1..15 so
  // four bits are always enough.
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  // Source of operand B
  typedef enum logic [1:0] {
    BSEL_RS2,
    BSEL_IMM,
    BSEL_ZERO
  } bsel_t;

  // How the zero flag turns into a branch decision
  typedef enum logic [1:0] {
    BR_NONE,
    BR_EQ,
    BR_NE
  } branch_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [3:0]      r_execCnt;
  logic [XLEN-1:0] r_aluA;
  logic [XLEN-1:0] r_aluB;
  logic [3:0]      r_aluCtl;
  branch_t         r_branch;
  logic [XLEN-1:0] r_rspResult;
  logic            r_rspTaken;
  logic            r_rspIllegal;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic            w_decLegal;
  logic [3:0]      w_decCtl;
  bsel_t           w_decBSel;
  branch_t         w_decBranch;
  logic [XLEN-1:0] w_decB;
  logic            w_reqReady;
  logic            w_accept;
  logic            w_execDone;
  logic            w_taken;

  assign w_opcode = i_req_instr[6:0];
  assign w_funct3 = i_req_instr[14:12];
  assign w_funct7 = i_req_instr[31:25];

  // Instruction decode.  Anything not explicitly listed falls through to the
  // defaults, which mark the request illegal.
  always_comb begin
    w_decLegal  = 1'b0;
    w_decCtl    = CTL_ADD;
    w_decBSel   = BSEL_RS2;
    w_decBranch = BR_NONE;
    unique case (w_opcode)
      OP_REG: begin
        unique case (w_funct3)
          3'b000: begin
            if (w_funct7 == 7'b0000000) begin
              w_decLegal = 1'b1;
              w_decCtl   = CTL_ADD;
            end else if (w_funct7 == 7'b0100000) begin
              w_decLegal = 1'b1;
              w_decCtl   = CTL_SUB;
            end
          end
          3'b010: begin
            w_decLegal = 1'b1;
            w_decCtl   = CTL_SLT;
          end
          3'b110: begin
            w_decLegal = 1'b1;
            w_decCtl   = CTL_OR;
          end
          3'b111: begin
            w_decLegal = 1'b1;
            w_decCtl   = CTL_AND;
          end
          default: ;
        endcase
      end
      OP_IMM: begin
        w_decBSel = BSEL_IMM;
        unique case (w_funct3)
          3'b000: begin
            w_decLegal = 1'b1;
            w_decCtl   = CTL_ADD;
          end
          3'b010: begin
            w_decLegal = 1'b1;
            w_decCtl   = CTL_SLT;
          end
          3'b110: begin
            w_decLegal = 1'b1;
            w_decCtl   = CTL_OR;
          end
          3'b111: begin
            w_decLegal = 1'b1;
            w_decCtl   = CTL_AND;
          end
          default: ;
        endcase
      end
      // Loads and stores only need the address sum
      OP_LOAD, OP_STORE: begin
        w_decLegal = 1'b1;
        w_decCtl   = CTL_ADD;
        w_decBSel  = BSEL_IMM;
      end
      // Branches compare by subtraction; the zero flag decides the outcome
      OP_BRANCH: begin
        w_decCtl = CTL_SUB;
        if (w_funct3 == 3'b000) begin
          w_decLegal  = 1'b1;
          w_decBranch = BR_EQ;
        end else if (w_funct3 == 3'b001) begin
          w_decLegal  = 1'b1;
          w_decBranch = BR_NE;
        end
      end
`ifdef ALU_TZCNT_EN
      OP_CUSTOM0: begin
        if (w_funct3 == 3'b001) begin
          w_decLegal = 1'b1;
          w_decCtl   = CTL_TZCNT;
          w_decBSel  = BSEL_ZERO;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_decB = i_req_rs2;
    unique case (w_decBSel)
      BSEL_IMM:  w_decB = i_req_imm;
      BSEL_ZERO: w_decB = '0;
      default:   w_decB = i_req_rs2;
    endcase
  end

  // A flush blocks acceptance in the same cycle so nothing slips in while
  // the pipeline is being cleared.
  assign w_reqReady = (r_state == S_IDLE) && !i_flush;
  assign w_accept   = i_req_valid && w_reqReady;
  assign w_execDone = (r_state == S_EXEC) && (r_execCnt == LAST_CNT);

  always_comb begin
    w_taken = 1'b0;
    unique case (r_branch)
      BR_EQ:   w_taken = i_alu_zero;
      BR_NE:   w_taken = !i_alu_zero;
      default: w_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nextState = w_decLegal ? S_EXEC : S_RESP;
        end
      end
      S_EXEC: begin
        if (w_execDone) begin
          w_nextState = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
    if (i_flush) begin
      w_nextState = S_IDLE;
    end
  end

  // Operand/control capture, hold counter and response capture.  The ALU
  // operands are only rewritten by a legal accept, so an illegal request
  // leaves the previous operation's values on the ALU inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_execCnt    <= '0;
      r_aluA       <= '0;
      r_aluB       <= '0;
      r_aluCtl     <= CTL_ADD;
      r_branch     <= BR_NONE;
      r_rspResult  <= '0;
      r_rspTaken   <= 1'b0;
      r_rspIllegal <= 1'b0;
    end else if (i_flush) begin
      r_execCnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_execCnt <= '0;
            if (w_decLegal) begin
              r_aluA   <= i_req_rs1;
              r_aluB   <= w_decB;
              r_aluCtl <= w_decCtl;
              r_branch <= w_decBranch;
            end else begin
              r_rspResult  <= '0;
              r_rspTaken   <= 1'b0;
              r_rspIllegal <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_execCnt <= r_execCnt + 4'd1;
          if (w_execDone) begin
            r_rspResult  <= i_alu_out;
            r_rspTaken   <= w_taken;
            r_rspIllegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready   = w_reqReady;
  assign o_rsp_valid   = (r_state == S_RESP);
  assign o_alu_a       = r_aluA;
  assign o_alu_b       = r_aluB;
  assign o_alu_ctl     = r_aluCtl;
  assign o_rsp_result  = r_rspResult;
  assign o_rsp_taken   = r_rspTaken;
  assign o_rsp_illegal = r_rspIllegal;

endmodule
